// File: rtl/car_overlay_if.sv
// Pixel-stream bundle between the road renderer, the car overlay and the VGA pins.
// The bench or renderer drives through master; the overlay attaches as slave.
interface car_overlay_if;
  logic        button_c;
  logic        button_l;
  logic        button_r;
  logic [7:0]  accel_x;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic [3:0]  in_red;
  logic [3:0]  in_green;
  logic [3:0]  in_blue;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [1:0]  game_state;

  modport master (
    output button_c, button_l, button_r, accel_x,
    output h_coord, v_coord, in_red, in_green, in_blue,
    input  red, green, blue, lives, score, game_state
  );

  modport slave (
    input  button_c, button_l, button_r, accel_x,
    input  h_coord, v_coord, in_red, in_green, in_blue,
    output red, green, blue, lives, score, game_state
  );
endinterface

// File: rtl/car_overlay.sv
// Player-car compositor on the road RGB stream, plus the per-frame
// PLAY/CRASH/OVER game loop with lives, score and steering.
module car_overlay #(
  parameter int H_PIXELS     = 800,
  parameter int V_PIXELS     = 600,
  parameter int CAR_W        = 20,
  parameter int CAR_H        = 32,
  parameter int CAR_Y        = 540,
  parameter int CAR_STEP     = 2,
  parameter int ACCEL_DZ     = 16,
  parameter int CRASH_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input logic         pixel_clk,
  input logic         rst_n,
  car_overlay_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CRASH = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [9:0] CENTRE = 10'(H_PIXELS / 2 - CAR_W / 2);
  localparam logic signed [11:0] X_MAX = 12'(H_PIXELS - CAR_W);
  localparam logic signed [11:0] STEP = 12'(CAR_STEP);
  localparam logic signed [7:0] DZ = 8'(ACCEL_DZ);
  localparam logic [11:0] OFF_ROAD = 12'h008;

  state_t      state_q, state_d;
  logic [10:0] h_q;
  logic [9:0]  v_q;
  logic [9:0]  car_x_q, car_x_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  crash_cnt_q, crash_cnt_d;
  logic        hit_q, hit_d;
  logic        btn_c_q;
  logic [11:0] rgb_q, rgb_d;

  logic [11:0] in_rgb;
  logic [10:0] x_lo, x_hi;
  logic        car_pix, eof, restart, coll;
  logic signed [7:0]  ax;
  logic signed [11:0] step, x_next;

  assign in_rgb = {bus.in_red, bus.in_green, bus.in_blue};
  assign ax     = bus.accel_x;

  // Car window is tested against the delayed coords that pair with in_rgb.
  assign x_lo    = {1'b0, car_x_q};
  assign x_hi    = x_lo + 11'(CAR_W - 1);
  assign car_pix = (h_q >= x_lo) && (h_q <= x_hi) &&
                   (v_q >= 10'(CAR_Y)) &&
                   (v_q <= 10'(CAR_Y + CAR_H - 1));

  assign eof = (bus.h_coord == 11'(H_PIXELS - 1)) &&
               (bus.v_coord == 10'(V_PIXELS - 1));

  assign coll    = car_pix && (state_q == PLAY) && (in_rgb == OFF_ROAD);
  assign restart = (state_q == OVER) && bus.button_c && !btn_c_q;

  always_comb begin
    step = '0;
    unique case (1'b1)
      bus.button_l && !bus.button_r:        step = -STEP;
      bus.button_r && !bus.button_l:        step = STEP;
      !bus.button_l && !bus.button_r && (ax > DZ):  step = STEP;
      !bus.button_l && !bus.button_r && (ax < -DZ): step = -STEP;
      default:                              step = '0;
    endcase
  end

  assign x_next = $signed({2'b00, car_x_q}) + step;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    car_x_d     = car_x_q;
    crash_cnt_d = crash_cnt_q;
    hit_d       = hit_q | coll;
    if (restart) begin
      state_d     = PLAY;
      lives_d     = 2'(LIVES);
      score_d     = '0;
      car_x_d     = CENTRE;
      crash_cnt_d = '0;
      hit_d       = 1'b0;
    end else if (eof) begin
      // A hit seen on the eof cycle itself belongs to the next frame.
      hit_d = coll;
      unique case (state_q)
        PLAY: begin
          if (hit_q && lives_q > 2'd1) begin
            state_d     = CRASH;
            lives_d     = lives_q - 2'd1;
            crash_cnt_d = 8'(CRASH_FRAMES);
            car_x_d     = CENTRE;
          end else if (hit_q) begin
            state_d = OVER;
            lives_d = '0;
          end else begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            if (x_next < 12'sd0)       car_x_d = '0;
            else if (x_next > X_MAX)   car_x_d = X_MAX[9:0];
            else                       car_x_d = x_next[9:0];
          end
        end
        CRASH: begin
          crash_cnt_d = crash_cnt_q - 8'd1;
          if (crash_cnt_q == 8'd1) state_d = PLAY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rgb_d = in_rgb;
    if (car_pix) begin
      unique case (state_q)
        PLAY:    rgb_d = 12'hF00;
        CRASH:   if (!crash_cnt_q[3]) rgb_d = 12'hFF0;
        OVER:    rgb_d = 12'h888;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      h_q         <= '0;
      v_q         <= '0;
      car_x_q     <= CENTRE;
      lives_q     <= 2'(LIVES);
      score_q     <= '0;
      crash_cnt_q <= '0;
      hit_q       <= 1'b0;
      btn_c_q     <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= bus.h_coord;
      v_q         <= bus.v_coord;
      car_x_q     <= car_x_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      crash_cnt_q <= crash_cnt_d;
      hit_q       <= hit_d;
      btn_c_q     <= bus.button_c;
      rgb_q       <= rgb_d;
    end
  end

  assign {bus.red, bus.green, bus.blue} = rgb_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_car_overlay.sv
// Random and directed stimulus for car_overlay against a frame-level
// reference model of the game rules and the 2-stage compositor.
module tb_car_overlay;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;

  car_overlay_if bus();

  car_overlay dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_x, m_lives, m_score, m_state, m_hit, m_cnt;
  int m_prev_c, m_hd, m_vd, m_rgb;

  int prev_h = 0;
  bit off_road = 0;
  int obs = 0;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(int x);
    if (x < 0) return 0;
    if (x > 780) return 780;
    return x;
  endfunction

  function automatic int steer(bit l, bit r, int a);
    if (l && !r) return -2;
    if (r && !l) return 2;
    if (l && r) return 0;
    if (a > 16) return 2;
    if (a < -16) return -2;
    return 0;
  endfunction

  task automatic model_reset();
    m_x = 390; m_lives = 3; m_score = 0; m_state = 0;
    m_hit = 0; m_cnt = 0; m_prev_c = 0;
    m_hd = 0; m_vd = 0; m_rgb = 0;
  endtask

  task automatic model_step();
    int inc, nrgb, a;
    bit on_car, at_eof, rise, coll;
    if (!rst_n) begin
      model_reset();
      return;
    end
    inc = {bus.in_red, bus.in_green, bus.in_blue};
    a = $signed(bus.accel_x);
    on_car = m_hd >= m_x && m_hd < m_x + 20 && m_vd >= 540 && m_vd < 572;
    at_eof = bus.h_coord == 799 && bus.v_coord == 599;
    rise = bus.button_c && !m_prev_c;
    nrgb = inc;
    if (on_car) begin
      if (m_state == 0) nrgb = 'hF00;
      else if (m_state == 1) nrgb = (m_cnt & 8) ? inc : 'hFF0;
      else nrgb = 'h888;
    end
    coll = on_car && m_state == 0 && inc == 'h008;
    if (m_state == 2 && rise) begin
      m_state = 0; m_lives = 3; m_score = 0;
      m_x = 390; m_hit = 0; m_cnt = 0;
    end else if (at_eof) begin
      if (m_state == 0) begin
        if (m_hit && m_lives > 1) begin
          m_state = 1; m_lives--; m_cnt = 60; m_x = 390;
        end else if (m_hit) begin
          m_state = 2; m_lives = 0;
        end else begin
          if (m_score < 65535) m_score++;
          m_x = clamp(m_x + steer(bus.button_l, bus.button_r, a));
        end
      end else if (m_state == 1) begin
        m_cnt--;
        if (m_cnt == 0) m_state = 0;
      end
      m_hit = coll;
    end else begin
      m_hit = m_hit | coll;
    end
    m_prev_c = bus.button_c;
    m_hd = bus.h_coord;
    m_vd = bus.v_coord;
    m_rgb = nrgb;
  endtask

  task automatic pix(int h, int v);
    int c;
    if (off_road) c = 'h008;
    else if (prev_h >= 355 && prev_h <= 445) c = 'hFFF;
    else c = 'h0A0;
    {bus.in_red, bus.in_green, bus.in_blue} = 12'(c);
    bus.h_coord = 11'(h);
    bus.v_coord = 10'(v);
    model_step();
    @(posedge pixel_clk);
    #1;
    obs = {bus.red, bus.green, bus.blue};
    check("rgb", obs, m_rgb);
    check("state", bus.game_state, m_state);
    check("lives", bus.lives, m_lives);
    check("score", bus.score, m_score);
    prev_h = h;
  endtask

  task automatic frame(int n);
    int h, v;
    pix(m_x + 10, 550);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 598);
      end else begin
        h = m_x - 4 + $urandom_range(0, 27);
        v = $urandom_range(530, 580);
        if (h < 0) h = 0;
        if (h > 799) h = 799;
      end
      pix(h, v);
    end
    pix(799, 599);
  endtask

  task automatic frames(int k);
    for (int i = 0; i < k; i++) frame(3);
  endtask

  // car edges: pixels at x and x+19 red, neighbours not
  task automatic probe(int x);
    pix(x - 1 < 0 ? 0 : x - 1, 550);
    pix(x, 550);
    if (x > 0) check("probe_left_out", obs == 'hF00, 0);
    pix(x + 19, 550);
    check("probe_left_in", obs, 'hF00);
    pix(x + 20, 550);
    check("probe_right_in", obs, 'hF00);
    pix(0, 0);
    check("probe_right_out", obs == 'hF00, 0);
  endtask

  task automatic crash_frame();
    off_road = 1;
    frame(3);
    off_road = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int yellow, sc;
    bus.button_c = 0; bus.button_l = 0; bus.button_r = 0;
    bus.accel_x = 0; bus.h_coord = 0; bus.v_coord = 0;
    bus.in_red = 0; bus.in_green = 0; bus.in_blue = 0;
    model_reset();

    rst_n = 0;
    pix(0, 0);
    pix(0, 0);
    check("rst_rgb", obs, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_score", bus.score, 0);
    check("rst_state", bus.game_state, 0);
    rst_n = 1;

    frames(10);
    check("idle_score", bus.score, 10);
    check("idle_state", bus.game_state, 0);
    probe(390);

    bus.button_r = 1;
    frames(5);
    probe(400);
    frames(190);
    probe(780);
    frames(5);
    probe(780);
    bus.button_r = 0;

    bus.accel_x = 8'd10;
    frames(3);
    probe(780);
    bus.accel_x = 8'($signed(-40));
    frames(5);
    probe(770);
    bus.button_r = 1;
    frames(3);
    probe(776);
    bus.button_l = 1;
    frames(2);
    probe(776);
    bus.button_l = 0; bus.button_r = 0; bus.accel_x = 0;

    crash_frame();
    check("crash1_state", bus.game_state, 1);
    check("crash1_lives", bus.lives, 2);
    yellow = 0;
    for (int f = 0; f < 60; f++) begin
      pix(400, 550);
      pix(0, 0);
      if (obs == 'hFF0) yellow++;
      frame(2);
    end
    check("crash1_yellow_frames", yellow, 31);
    check("crash1_back_play", bus.game_state, 0);
    probe(390);

    crash_frame();
    check("crash2_lives", bus.lives, 1);
    frames(60);
    check("crash2_back_play", bus.game_state, 0);
    crash_frame();
    check("over_state", bus.game_state, 2);
    check("over_lives", bus.lives, 0);
    pix(400, 550);
    pix(0, 0);
    check("over_grey", obs, 'h888);
    sc = m_score;
    frames(3);
    check("over_score_frozen", bus.score, sc);

    // restart edge on the eof cycle wins over the frame update
    bus.button_c = 1;
    pix(799, 599);
    check("restart_state", bus.game_state, 0);
    check("restart_lives", bus.lives, 3);
    check("restart_score", bus.score, 0);
    bus.button_c = 0;
    probe(390);

    crash_frame();
    check("pre_rst_crash", bus.game_state, 1);
    pix(100, 100);
    pix(400, 560);
    rst_n = 0;
    pix(300, 550);
    check("midrst_state", bus.game_state, 0);
    check("midrst_lives", bus.lives, 3);
    check("midrst_score", bus.score, 0);
    check("midrst_rgb", obs, 0);
    rst_n = 1;

    for (int f = 0; f < 200; f++) begin
      bus.button_l = ($urandom_range(0, 2) == 0);
      bus.button_r = ($urandom_range(0, 2) == 0);
      bus.accel_x = 8'($urandom_range(0, 255));
      bus.button_c = ($urandom_range(0, 4) == 0);
      off_road = ($urandom_range(0, 11) == 0);
      frame($urandom_range(2, 6));
    end
    off_road = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
